systolic_feeder: RTL

Input staging and skew stage placed directly upstream of the MAC array. It buffers incoming activation row vectors in a small FIFO and launches them one per cycle. Each launched vector is diagonally skewed: lane i is delayed by i cycles, so the wavefront enters the array's left edge correctly aligned. It drives the array's `values_in1` bus, inserts zero bubbles when starved, and flushes the pipeline after the last vector of a batch.

---
 rtl/systolic_feeder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/systolic_feeder.sv
// Input staging FIFO plus diagonal skew chain feeding the MAC array's values_in1 bus.
// Vectors are popped one per cycle while streaming; lane i of an issued vector emerges i cycles after lane 0.
module systolic_feeder #(
    parameter int unsigned DATA_SIZE  = 8,
    parameter int unsigned MAC_WIDTH  = 256,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [MAC_WIDTH*DATA_SIZE-1:0] in_vector,
    input  logic                           in_last,
    input  logic                           start,
    output logic [MAC_WIDTH*DATA_SIZE-1:0] values_out,
    output logic [MAC_WIDTH-1:0]           out_valid,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned VW = MAC_WIDTH * DATA_SIZE;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = (MAC_WIDTH > 1) ? $clog2(MAC_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  drain_cnt, drain_cnt_nx;
    logic           done_r, done_nx;

    logic [VW-1:0]  mem_vec  [FIFO_DEPTH];
    logic           mem_last [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [PW:0]    count;
    logic           full, empty, push, pop;
    logic [VW-1:0]  issue_vec;

    assign full     = (count == (PW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    // Full blocks the push even when a pop frees a slot in the same cycle.
    assign push     = in_valid && !full;

    always_ff @(posedge clock) begin
        if (push) begin
            mem_vec[wr_ptr]  <= in_vector;
            mem_last[wr_ptr] <= in_last;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            drain_cnt <= '0;
            done_r    <= 1'b0;
        end else begin
            state     <= state_nx;
            drain_cnt <= drain_cnt_nx;
            done_r    <= done_nx;
        end
    end

    // done is registered so it lands on the cycle the last vector's top lane is visible.
    always_comb begin
        state_nx     = state;
        drain_cnt_nx = drain_cnt;
        done_nx      = 1'b0;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = STREAM;
            end
            STREAM: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (mem_last[rd_ptr]) begin
                        if (MAC_WIDTH == 1) begin
                            state_nx = IDLE;
                            done_nx  = 1'b1;
                        end else begin
                            state_nx     = DRAIN;
                            drain_cnt_nx = CW'(MAC_WIDTH - 1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == CW'(1)) done_nx = 1'b1;
                if (drain_cnt == '0) begin
                    state_nx = IDLE;
                end else begin
                    drain_cnt_nx = drain_cnt - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign done      = done_r;
    assign issue_vec = pop ? mem_vec[rd_ptr] : '0;

    // Lane g is a shift chain of g+1 registers; a bubble shifts in zero data with valid low.
    for (genvar g = 0; g < MAC_WIDTH; g++) begin : g_lane
        localparam int unsigned STAGES = g + 1;
        logic [DATA_SIZE-1:0] stage_data [STAGES];
        logic                 stage_vld  [STAGES];

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int unsigned k = 0; k < STAGES; k++) begin
                    stage_data[k] <= '0;
                    stage_vld[k]  <= 1'b0;
                end
            end else begin
                stage_data[0] <= issue_vec[g*DATA_SIZE +: DATA_SIZE];
                stage_vld[0]  <= pop;
                for (int unsigned k = 1; k < STAGES; k++) begin
                    stage_data[k] <= stage_data[k-1];
                    stage_vld[k]  <= stage_vld[k-1];
                end
            end
        end

        assign values_out[g*DATA_SIZE +: DATA_SIZE] = stage_data[STAGES-1];
        assign out_valid[g]                         = stage_vld[STAGES-1];
    end

endmodule
